// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard, two combinational read ports, one write port, one reserve port.
// Latency: writes are visible on the read ports the cycle after the write edge; REGFILE_BYPASS_EN forwards them in the same cycle.
// Backpressure: none; every write and reserve is accepted, and reserving a busy register raises a one-cycle rsv_err pulse.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic wr_hit;
  logic rsv_hit;
  logic wr_rsv_same;
  logic set_evt;
  logic clr_evt;
  logic err_nxt;

  // Address 0 is hardwired: it is never written and never marked busy.
  assign wr_hit      = wr_en && (wr_addr != '0);
  assign rsv_hit     = rsv_en && (rsv_addr != '0);
  assign wr_rsv_same = wr_hit && rsv_hit && (wr_addr == rsv_addr);

  // A same-edge write completes the old reservation, so a re-reserve is legal there.
  assign set_evt = rsv_hit && !busy[rsv_addr];
  assign clr_evt = wr_hit && busy[wr_addr] && !wr_rsv_same;
  assign err_nxt = rsv_hit && busy[rsv_addr] && !wr_rsv_same;

  always_comb begin
    busy_nxt = busy;
    if (wr_hit) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (rsv_hit) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      rsv_err  <= 1'b0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      rsv_err  <= err_nxt;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(set_evt) - (ADDR_W+1)'(clr_evt);
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data1 = mem[rd_addr1];
    rd_busy1 = busy[rd_addr1];
    rd_data2 = mem[rd_addr2];
    rd_busy2 = busy[rd_addr2];
    if (wr_hit && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
      rd_busy1 = wr_rsv_same;
    end
    if (wr_hit && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
      rd_busy2 = wr_rsv_same;
    end
  end
`else
  assign rd_data1 = mem[rd_addr1];
  assign rd_busy1 = busy[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign rd_busy2 = busy[rd_addr2];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, corner sequences, randomized run against a reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_err;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(rsv_err), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        err;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vt[13];

  // Reference state: register contents and pending flags as plain arrays.
  logic [31:0] mdata [32];
  bit          mbusy [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_ops();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mdata[i] = '0;
      mbusy[i] = 0;
    end
  endtask

  function automatic int model_cnt();
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(mbusy[i]);
    return s;
  endfunction

  task automatic apply_vec(input int i);
    wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
    rsv_en = vt[i].re; rsv_addr = vt[i].ra;
    edge_step();
    idle_ops();
    rd_addr1 = vt[i].r1; rd_addr2 = vt[i].r2;
    #1;
    check($sformatf("vec%0d rd_data1", i), rd_data1, vt[i].d1);
    check($sformatf("vec%0d rd_busy1", i), 32'(rd_busy1), 32'(vt[i].b1));
    check($sformatf("vec%0d rd_data2", i), rd_data2, vt[i].d2);
    check($sformatf("vec%0d rd_busy2", i), 32'(rd_busy2), 32'(vt[i].b2));
    check($sformatf("vec%0d rsv_err", i), 32'(rsv_err), 32'(vt[i].err));
    check($sformatf("vec%0d busy_cnt", i), 32'(busy_cnt), 32'(vt[i].cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_ops();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    //        we  wa  wd            re  ra  r1  r2  d1            b1  d2            b2  err cnt
    vt[0]  = '{0, 0,  32'h0,        0,  0,  5,  31, 32'h0,        0,  32'h0,        0,  0,  0};
    vt[1]  = '{1, 5,  32'hDEADBEEF, 0,  0,  5,  0,  32'hDEADBEEF, 0,  32'h0,        0,  0,  0};
    vt[2]  = '{1, 0,  32'h1234,     0,  0,  0,  5,  32'h0,        0,  32'hDEADBEEF, 0,  0,  0};
    vt[3]  = '{0, 0,  32'h0,        1,  7,  7,  9,  32'h0,        1,  32'h0,        0,  0,  1};
    vt[4]  = '{0, 0,  32'h0,        1,  9,  7,  9,  32'h0,        1,  32'h0,        1,  0,  2};
    vt[5]  = '{1, 7,  32'hA5,       0,  0,  7,  9,  32'hA5,       0,  32'h0,        1,  0,  1};
    vt[6]  = '{0, 0,  32'h0,        1,  3,  3,  9,  32'h0,        1,  32'h0,        1,  0,  2};
    vt[7]  = '{0, 0,  32'h0,        1,  3,  3,  9,  32'h0,        1,  32'h0,        1,  1,  2};
    vt[8]  = '{0, 0,  32'h0,        0,  0,  3,  9,  32'h0,        1,  32'h0,        1,  0,  2};
    vt[9]  = '{1, 3,  32'h77,       1,  3,  3,  9,  32'h77,       1,  32'h0,        1,  0,  2};
    vt[10] = '{1, 9,  32'h99,       1,  4,  4,  9,  32'h0,        1,  32'h99,       0,  0,  2};
    vt[11] = '{0, 0,  32'h0,        1,  0,  0,  3,  32'h0,        0,  32'h77,       1,  0,  2};
    vt[12] = '{1, 5,  32'h11,       0,  0,  5,  4,  32'h11,       0,  32'h0,        1,  0,  2};

    rd_addr1 = '0; rd_addr2 = '0;
    reset = 1'b1;
    idle_ops();
    #3;
    check("in_reset busy_cnt", 32'(busy_cnt), 32'd0);
    check("in_reset rsv_err", 32'(rsv_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
      #1;
      check($sformatf("reset rd_data1[%0d]", a), rd_data1, 32'h0);
      check($sformatf("reset rd_busy2[%0d]", a), 32'(rd_busy2), 32'h0);
    end
    check("reset busy_cnt", 32'(busy_cnt), 32'd0);

    for (int i = 0; i < 13; i++) apply_vec(i);

    // Mid-operation reset with three registers pending (3, 4 from the table, plus 10).
    rsv_en = 1'b1; rsv_addr = 5'd10;
    edge_step();
    idle_ops();
    check("pre_reset busy_cnt", 32'(busy_cnt), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async reset busy_cnt", 32'(busy_cnt), 32'd0);
    rd_addr1 = 5'd5; rd_addr2 = 5'd3;
    #1;
    check("async reset rd_data1", rd_data1, 32'h0);
    check("async reset rd_busy2", 32'(rd_busy2), 32'h0);
    // Operations presented during reset must be dropped.
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    edge_step();
    idle_ops();
    reset = 1'b0;
    edge_step();
    rd_addr1 = 5'd6; rd_addr2 = 5'd3;
    #1;
    check("post_reset rd_data1", rd_data1, 32'h0);
    check("post_reset rd_busy2", 32'(rd_busy2), 32'h0);
    check("post_reset busy_cnt", 32'(busy_cnt), 32'd0);
    check("post_reset rsv_err", 32'(rsv_err), 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    edge_step();
    idle_ops();
    check("post_reset rereserve rsv_err", 32'(rsv_err), 32'd0);
    check("post_reset rereserve busy_cnt", 32'(busy_cnt), 32'd1);

    // Same-cycle read of a register being written.
    do_reset();
    rd_addr1 = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass same-cycle rd_data1", rd_data1, 32'h55);
`else
    check("no-bypass same-cycle rd_data1", rd_data1, 32'h0);
`endif
    edge_step();
    idle_ops();
    #1;
    check("write next-cycle rd_data1", rd_data1, 32'h55);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        we, re, exp_err;
      logic [4:0]  wa, ra, r1, r2;
      logic [31:0] wd, e1, e2;
      bit          eb1, eb2;
      bit          narrow;
      narrow = ($urandom_range(3) != 0);
      we = 1'($urandom_range(1));
      re = 1'($urandom_range(1));
      wa = narrow ? 5'($urandom_range(7)) : 5'($urandom);
      ra = narrow ? 5'($urandom_range(7)) : 5'($urandom);
      r1 = narrow ? 5'($urandom_range(7)) : 5'($urandom);
      r2 = ($urandom_range(1) != 0) ? wa : 5'($urandom);
      wd = $urandom;
      wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = re; rsv_addr = ra;
      rd_addr1 = r1; rd_addr2 = r2;
      #1;
      e1 = mdata[r1]; eb1 = mbusy[r1];
      e2 = mdata[r2]; eb2 = mbusy[r2];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && r1 == wa) begin e1 = wd; eb1 = re && (ra == wa); end
      if (we && wa != 0 && r2 == wa) begin e2 = wd; eb2 = re && (ra == wa); end
`endif
      check("rand rd_data1", rd_data1, e1);
      check("rand rd_busy1", 32'(rd_busy1), 32'(eb1));
      check("rand rd_data2", rd_data2, e2);
      check("rand rd_busy2", 32'(rd_busy2), 32'(eb2));
      exp_err = re && ra != 0 && mbusy[ra] && !(we && wa == ra);
      if (we && wa != 0) begin mdata[wa] = wd; mbusy[wa] = 0; end
      if (re && ra != 0) mbusy[ra] = 1;
      edge_step();
      check("rand rsv_err", 32'(rsv_err), 32'(exp_err));
      check("rand busy_cnt", 32'(busy_cnt), 32'(model_cnt()));
    end
    idle_ops();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
